// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [3:0] OPCODE_HALT = 4'hF;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus2;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with wrap/mask logic and next-PC mux
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus2
);

    // IMEM_BYTES is a power of two, so modulo reduces to an AND mask
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(IMEM_BYTES - 1);

    logic [ADDR_W-1:0] pc_next;

    assign pc_plus2 = (pc + 16'd2) & PC_MASK;

    // Redirect target wins over sequential advance; targets are halfword aligned
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = target & PC_MASK & 16'hFFFE;
        end else if (advance) begin
            pc_next = pc_plus2;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage with IF/ID register (optional perf counters: FETCH_PERF_EN)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          IMEM_BYTES  = 128,
    parameter logic [3:0]  HALT_OPCODE = OPCODE_HALT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic [ADDR_W-1:0]  imem_address,
    output logic               imem_enable,
    output logic               imem_rw,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus2,
    output logic               if_id_valid,
`ifdef FETCH_PERF_EN
    output logic [15:0]        perf_fetch_count,
    output logic [15:0]        perf_stall_count,
`endif
    output logic               halted
);

    state_t            state;
    state_t            state_next;
    if_id_t            if_id;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus2;
    logic              pc_load;
    logic              do_fetch;
    logic              clr_valid;

    fetch_pc_reg #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .target   (redirect_target),
        .advance  (do_fetch),
        .pc       (pc),
        .pc_plus2 (pc_plus2)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control: redirect > flush > stall > normal fetch
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        do_fetch   = 1'b0;
        clr_valid  = 1'b0;
        case (state)
            START: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_load   = 1'b1;
                    clr_valid = 1'b1;
                end else if (flush) begin
                    clr_valid = 1'b1;
                end else if (!stall) begin
                    do_fetch = 1'b1;
                    if (imem_instruction[15:12] == HALT_OPCODE) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                // A stalled decode keeps the halt instruction visible until it drains
                clr_valid = !(stall && !flush && !redirect_valid);
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id <= '0;
        end else if (do_fetch) begin
            if_id <= '{instr: imem_instruction, pc: pc, pc_plus2: pc_plus2, valid: 1'b1};
        end else if (clr_valid) begin
            if_id.valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters, free-running and wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_count <= 16'h0000;
            perf_stall_count <= 16'h0000;
        end else begin
            if (do_fetch) begin
                perf_fetch_count <= perf_fetch_count + 16'd1;
            end
            if (state == FETCH && stall && !redirect_valid) begin
                perf_stall_count <= perf_stall_count + 16'd1;
            end
        end
    end
`endif

    assign imem_address   = pc;
    assign imem_enable    = (state != FETCH);
    assign imem_rw        = 1'b1;
    assign halted         = (state == HALT);
    assign if_id_instr    = if_id.instr;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus2 = if_id.pc_plus2;
    assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] imem_instruction;
    logic [15:0] imem_address;
    logic        imem_enable;
    logic        imem_rw;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_count;
    logic [15:0] perf_stall_count;
`endif

    logic [15:0] mem [0:63];
    int          n_assert;
    int          n_fail;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_instruction (imem_instruction),
        .imem_address     (imem_address),
        .imem_enable      (imem_enable),
        .imem_rw          (imem_rw),
        .if_id_instr      (if_id_instr),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus2   (if_id_pc_plus2),
        .if_id_valid      (if_id_valid),
`ifdef FETCH_PERF_EN
        .perf_fetch_count (perf_fetch_count),
        .perf_stall_count (perf_stall_count),
`endif
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory, halfword addressed
    assign imem_instruction = mem[imem_address[6:1]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] instr, input logic [15:0] pc,
                            input logic [15:0] pc2, input logic valid);
        chk({tag, "_instr"}, if_id_instr, instr);
        chk({tag, "_pc"}, if_id_pc, pc);
        chk({tag, "_pc2"}, if_id_pc_plus2, pc2);
        chk({tag, "_valid"}, {15'd0, if_id_valid}, {15'd0, valid});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i * 2);
        mem[16'h00 >> 1] = 16'h0120;
        mem[16'h02 >> 1] = 16'h0121;
        mem[16'h04 >> 1] = 16'h23FF;
        mem[16'h06 >> 1] = 16'h134C;
        mem[16'h08 >> 1] = 16'h0564;
        mem[16'h24 >> 1] = 16'h0110;
        mem[16'h36 >> 1] = 16'hF000;

        reset           = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", imem_address, 16'h0000);
        chk("rst_en", {15'd0, imem_enable}, 16'd1);
        chk("rst_rw", {15'd0, imem_rw}, 16'd1);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk_ifid("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        reset = 1'b1;
        chk("start_en", {15'd0, imem_enable}, 16'd1);
        step();
        chk("fetch_en", {15'd0, imem_enable}, 16'd0);
        chk("fetch_valid0", {15'd0, if_id_valid}, 16'd0);
        chk("fetch_addr0", imem_address, 16'h0000);

        step();
        chk_ifid("f0", 16'h0120, 16'h0000, 16'h0002, 1'b1);
        step();
        chk_ifid("f1", 16'h0121, 16'h0002, 16'h0004, 1'b1);
        step();
        chk_ifid("f2", 16'h23FF, 16'h0004, 16'h0006, 1'b1);
        chk("f2_addr", imem_address, 16'h0006);

        stall = 1'b1;
        step();
        chk("stall1_addr", imem_address, 16'h0006);
        chk_ifid("stall1", 16'h23FF, 16'h0004, 16'h0006, 1'b1);
        step();
        chk("stall2_addr", imem_address, 16'h0006);
        chk_ifid("stall2", 16'h23FF, 16'h0004, 16'h0006, 1'b1);
        stall = 1'b0;
        step();
        chk_ifid("f3", 16'h134C, 16'h0006, 16'h0008, 1'b1);
        chk("f3_addr", imem_address, 16'h0008);

        flush = 1'b1;
        step();
        chk("flush_valid", {15'd0, if_id_valid}, 16'd0);
        chk("flush_addr", imem_address, 16'h0008);
        flush = 1'b0;
        step();
        chk_ifid("f4", 16'h0564, 16'h0008, 16'h000A, 1'b1);

        redirect_valid  = 1'b1;
        redirect_target = 16'h0025;
        stall           = 1'b1;
        step();
        chk("redir_addr", imem_address, 16'h0024);
        chk("redir_valid", {15'd0, if_id_valid}, 16'd0);
        chk("redir_hold", if_id_instr, 16'h0564);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        chk_ifid("f5", 16'h0110, 16'h0024, 16'h0026, 1'b1);

        redirect_valid  = 1'b1;
        redirect_target = 16'h0034;
        step();
        chk("redir34_addr", imem_address, 16'h0034);
        redirect_valid = 1'b0;
        step();
        chk_ifid("f34", 16'h1034, 16'h0034, 16'h0036, 1'b1);
        step();
        chk_ifid("fhalt", 16'hF000, 16'h0036, 16'h0038, 1'b1);
        chk("fhalt_halted", {15'd0, halted}, 16'd1);
        chk("fhalt_en", {15'd0, imem_enable}, 16'd1);
        chk("fhalt_addr", imem_address, 16'h0038);
        step();
        chk("halt_valid", {15'd0, if_id_valid}, 16'd0);
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_en", {15'd0, imem_enable}, 16'd1);
        chk("halt_addr", imem_address, 16'h0038);
        step();
        chk("halt2_addr", imem_address, 16'h0038);

        redirect_valid  = 1'b1;
        redirect_target = 16'h0000;
        step();
        chk("resume_halted", {15'd0, halted}, 16'd0);
        chk("resume_en", {15'd0, imem_enable}, 16'd0);
        chk("resume_addr", imem_address, 16'h0000);
        redirect_valid = 1'b0;
        step();
        chk_ifid("resume_f", 16'h0120, 16'h0000, 16'h0002, 1'b1);

        redirect_valid  = 1'b1;
        redirect_target = 16'h007E;
        step();
        chk("wrap_addr0", imem_address, 16'h007E);
        redirect_valid = 1'b0;
        step();
        chk_ifid("wrap", 16'h107E, 16'h007E, 16'h0000, 1'b1);
        chk("wrap_addr1", imem_address, 16'h0000);

        #3;
        reset = 1'b0;
        #1;
        chk("arst_addr", imem_address, 16'h0000);
        chk("arst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("arst_instr", if_id_instr, 16'h0000);
        chk("arst_en", {15'd0, imem_enable}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
